hazard_ctrl: RTL

- Pipeline hazard and redirect controller that drives the stall/flush inputs of the IF/ID and ID/EX registers and the PC.
- Detects load-use hazards and taken branches/jumps resolved in EX, and holds the front end during multi-cycle MDU operations.
- Sits beside the pipeline registers; it is the generator side of the stall/flush interface that the pipeline registers consume.

---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_ctrl_hazard_detect.sv | 22 ++
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         ADDR_W   = 32;

endpackage

// File: rtl/hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose rd feeds a source read in ID.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] idRs1In,
  input  logic [4:0] idRs2In,
  input  logic       idUsesRs1In,
  input  logic       idUsesRs2In,
  input  logic [4:0] exRdIn,
  input  logic       exMemReadIn,
  output logic       loadUseOut
);

  logic rs1Match;
  logic rs2Match;

  assign rs1Match   = idUsesRs1In && (idRs1In == exRdIn);
  assign rs2Match   = idUsesRs2In && (idRs2In == exRdIn);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign loadUseOut = exMemReadIn && (exRdIn != REG_ZERO) && (rs1Match || rs2Match);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and redirect controller: generates PC / IF-ID / ID-EX stall and flush controls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MDU_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic              clkIn,
  input  logic              resetIn,
  input  logic [4:0]        idRs1In,
  input  logic [4:0]        idRs2In,
  input  logic              idUsesRs1In,
  input  logic              idUsesRs2In,
  input  logic [4:0]        exRdIn,
  input  logic              exMemReadIn,
  input  logic              exRedirectIn,
  input  logic [ADDR_W-1:0] exTargetIn,
  input  logic              mduStartIn,
  input  logic              mduDoneIn,
  output logic              pcStallOut,
  output logic              pcLoadOut,
  output logic [ADDR_W-1:0] pcTargetOut,
  output logic              ifidStallOut,
  output logic              ifidFlushOut,
  output logic              idexStallOut,
  output logic              idexFlushOut,
  output logic [CNT_W-1:0]  stallCntOut,
  output logic              errOut,
  output logic [1:0]        stateOut
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [9:0] MDU_LIMIT  = 10'(MDU_TIMEOUT);

  state_e     state, nextState;
  logic [2:0] flushCnt, flushCntNext;
  logic [9:0] mduCnt, mduCntNext;
  logic       errNext;
  logic       loadUse;

  hazard_detect uDetect (
    .idRs1In     (idRs1In),
    .idRs2In     (idRs2In),
    .idUsesRs1In (idUsesRs1In),
    .idUsesRs2In (idUsesRs2In),
    .exRdIn      (exRdIn),
    .exMemReadIn (exMemReadIn),
    .loadUseOut  (loadUse)
  );

  assign stateOut = state;

  always_comb begin
    pcStallOut   = 1'b0;
    pcLoadOut    = 1'b0;
    pcTargetOut  = '0;
    ifidStallOut = 1'b0;
    ifidFlushOut = 1'b0;
    idexStallOut = 1'b0;
    idexFlushOut = 1'b0;
    nextState    = state;
    flushCntNext = flushCnt;
    mduCntNext   = mduCnt;
    errNext      = errOut;

    // EX is frozen during MDU_WAIT, so a redirect seen there is stale and ignored.
    if (exRedirectIn && (state != MDU_WAIT)) begin
      pcLoadOut    = 1'b1;
      pcTargetOut  = exTargetIn;
      ifidFlushOut = 1'b1;
      idexFlushOut = 1'b1;
      flushCntNext = FLUSH_INIT;
      nextState    = (FLUSH_INIT != 3'd0) ? FLUSH : RUN;
    end else begin
      case (state)
        RUN: begin
          if (mduStartIn) begin
            pcStallOut   = 1'b1;
            ifidStallOut = 1'b1;
            idexStallOut = 1'b1;
            mduCntNext   = 10'd1;
            nextState    = MDU_WAIT;
          end else if (loadUse) begin
            pcStallOut   = 1'b1;
            ifidStallOut = 1'b1;
            idexFlushOut = 1'b1;
          end
        end
        FLUSH: begin
          ifidFlushOut = 1'b1;
          flushCntNext = flushCnt - 3'd1;
          if (flushCnt <= 3'd1) nextState = RUN;
        end
        MDU_WAIT: begin
          if (mduDoneIn) begin
            nextState = RUN;
          end else if (mduCnt >= MDU_LIMIT) begin
            errNext   = 1'b1;
            nextState = RUN;
          end else begin
            pcStallOut   = 1'b1;
            ifidStallOut = 1'b1;
            idexStallOut = 1'b1;
            mduCntNext   = mduCnt + 10'd1;
          end
        end
        default: nextState = RUN;
      endcase
    end

    // Reset holds both pipeline registers as bubbles and suppresses everything else.
    if (resetIn) begin
      pcStallOut   = 1'b0;
      pcLoadOut    = 1'b0;
      pcTargetOut  = '0;
      ifidStallOut = 1'b0;
      ifidFlushOut = 1'b1;
      idexStallOut = 1'b0;
      idexFlushOut = 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state       <= RUN;
      flushCnt    <= '0;
      mduCnt      <= '0;
      stallCntOut <= '0;
      errOut      <= 1'b0;
    end else begin
      state    <= nextState;
      flushCnt <= flushCntNext;
      mduCnt   <= mduCntNext;
      errOut   <= errNext;
      if (pcStallOut && (stallCntOut != {CNT_W{1'b1}})) stallCntOut <= stallCntOut + 1'b1;
    end
  end

endmodule
